// File: rtl/vmujs_pkg.sv
// Shared encodings for the JS value-stack command path: entry kinds, stack ops, sequencer states.
// Pure declarations; no timing or flow-control behaviour of its own.
package vmujs_pkg;

  typedef enum logic [2:0] {
    KIND_VOID = 3'd0,
    KIND_STR  = 3'd1,
    KIND_INT  = 3'd2,
    KIND_BOOL = 3'd3,
    KIND_NULL = 3'd4
  } kind_e;

  typedef enum logic [2:0] {
    OP_NEW_OBJ   = 3'd0,
    OP_PUSH_STR  = 3'd1,
    OP_PUSH_INT  = 3'd2,
    OP_PUSH_BOOL = 3'd3,
    OP_PUSH_NULL = 3'd4,
    OP_SET_PROP  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NEW  = 2'd1,
    ST_VAL  = 2'd2,
    ST_SET  = 2'd3
  } seq_state_e;

  // Object sits just below the pushed value when SET_PROP executes
  localparam logic [7:0] STACK_IDX_OBJ = 8'hFE;

  function automatic logic is_pushable(input logic [2:0] kind);
    return (kind >= 3'd1) && (kind <= 3'd4);
  endfunction

  function automatic logic [2:0] push_op(input logic [2:0] kind);
    case (kind)
      KIND_STR:  return OP_PUSH_STR;
      KIND_INT:  return OP_PUSH_INT;
      KIND_BOOL: return OP_PUSH_BOOL;
      default:   return OP_PUSH_NULL;
    endcase
  endfunction

endpackage

// File: rtl/obj_cmd_sequencer.sv
// Map entries -> NEW_OBJ / PUSH / SET_PROP commands; first command 1 cycle after accept, 2 cycles/entry.
// Backpressure: commands hold while cmd_ready low, in_ready drops until the last command drains; OBJ_SEQ_STATS_EN adds counters.
module obj_cmd_sequencer
  import vmujs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEY_W  = 16
`ifdef OBJ_SEQ_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [2:0]        in_kind,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [DATA_W-1:0] in_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_op,
  output logic [7:0]        cmd_idx,
  output logic [DATA_W-1:0] cmd_arg,
  output logic              obj_done,
  output logic              err_orphan
`ifdef OBJ_SEQ_STATS_EN
  , output logic [CNT_W-1:0] stat_entries
  , output logic [CNT_W-1:0] stat_skipped
  , output logic [CNT_W-1:0] stat_objects
`endif
);

  typedef struct packed {
    logic              last;
    logic [2:0]        kind;
    logic [KEY_W-1:0]  key;
    logic [DATA_W-1:0] data;
  } ent_t;

  seq_state_e        state_q, state_d;
  ent_t              ent_q, ent_d;
  logic              obj_open_q, obj_open_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [2:0]        cmd_op_q, cmd_op_d;
  logic [7:0]        cmd_idx_q, cmd_idx_d;
  logic [DATA_W-1:0] cmd_arg_q, cmd_arg_d;
  logic              cmd_hs, accept, open_eff;

  function automatic logic [DATA_W-1:0] push_arg(input logic [2:0] kind, input logic [DATA_W-1:0] data);
    case (kind)
      KIND_STR, KIND_INT: return data;
      KIND_BOOL:          return DATA_W'(data[0]);
      default:            return '0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    ent_d       = ent_q;
    obj_open_d  = obj_open_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_idx_d   = cmd_idx_q;
    cmd_arg_d   = cmd_arg_q;
    obj_done    = 1'b0;
    err_orphan  = 1'b0;
    open_eff    = obj_open_q;
    cmd_hs      = cmd_valid_q && cmd_ready;
    in_ready    = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_SET) && cmd_ready));
    accept      = in_valid && in_ready;

    case (state_q)
      ST_NEW: if (cmd_hs) begin
        if (is_pushable(ent_q.kind)) begin
          cmd_op_d  = push_op(ent_q.kind);
          cmd_idx_d = '0;
          cmd_arg_d = push_arg(ent_q.kind, ent_q.data);
          state_d   = ST_VAL;
        end else begin
          cmd_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (ent_q.last) begin
            obj_done   = 1'b1;
            obj_open_d = 1'b0;
          end
        end
      end
      ST_VAL: if (cmd_hs) begin
        cmd_op_d  = OP_SET_PROP;
        cmd_idx_d = STACK_IDX_OBJ;
        cmd_arg_d = DATA_W'(ent_q.key);
        state_d   = ST_SET;
      end
      ST_SET: if (cmd_hs) begin
        cmd_valid_d = 1'b0;
        state_d     = ST_IDLE;
        if (ent_q.last) begin
          obj_done   = 1'b1;
          obj_open_d = 1'b0;
          open_eff   = 1'b0;
        end
      end
      default: ;
    endcase

    // Accept overrides the drain path above when it lands on the SET handshake
    if (accept) begin
      ent_d = '{last: in_last, kind: in_kind, key: in_key, data: in_data};
      if (in_first) begin
        if (open_eff) obj_done = 1'b1;
        obj_open_d  = 1'b1;
        cmd_valid_d = 1'b1;
        cmd_op_d    = OP_NEW_OBJ;
        cmd_idx_d   = '0;
        cmd_arg_d   = '0;
        state_d     = ST_NEW;
      end else if (!open_eff) begin
        err_orphan  = 1'b1;
        cmd_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end else if (is_pushable(in_kind)) begin
        cmd_valid_d = 1'b1;
        cmd_op_d    = push_op(in_kind);
        cmd_idx_d   = '0;
        cmd_arg_d   = push_arg(in_kind, in_data);
        state_d     = ST_VAL;
      end else begin
        cmd_valid_d = 1'b0;
        state_d     = ST_IDLE;
        if (in_last) begin
          obj_done   = 1'b1;
          obj_open_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ent_q       <= '0;
      obj_open_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_idx_q   <= '0;
      cmd_arg_q   <= '0;
    end else begin
      state_q     <= state_d;
      ent_q       <= ent_d;
      obj_open_q  <= obj_open_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_idx_q   <= cmd_idx_d;
      cmd_arg_q   <= cmd_arg_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_idx   = cmd_idx_q;
  assign cmd_arg   = cmd_arg_q;

`ifdef OBJ_SEQ_STATS_EN
  logic             skip_ev;
  logic [CNT_W-1:0] stat_entries_q, stat_skipped_q, stat_objects_q;

  assign skip_ev = accept && !is_pushable(in_kind) && (in_first || open_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_entries_q <= '0;
      stat_skipped_q <= '0;
      stat_objects_q <= '0;
    end else begin
      if (accept && (stat_entries_q != '1))   stat_entries_q <= stat_entries_q + 1'b1;
      if (skip_ev && (stat_skipped_q != '1))  stat_skipped_q <= stat_skipped_q + 1'b1;
      if (obj_done && (stat_objects_q != '1)) stat_objects_q <= stat_objects_q + 1'b1;
    end
  end

  assign stat_entries = stat_entries_q;
  assign stat_skipped = stat_skipped_q;
  assign stat_objects = stat_objects_q;
`endif

endmodule

// File: tb/tb_obj_cmd_sequencer.sv
// Bench for obj_cmd_sequencer: entry-level queue model plus hand-computed literal expectations.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_obj_cmd_sequencer;
  localparam int DW = 32;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [2:0]    in_kind = '0;
  logic [KW-1:0] in_key = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, cmd_valid, obj_done, err_orphan;
  logic          cmd_ready = 1'b1;
  logic [2:0]    cmd_op;
  logic [7:0]    cmd_idx;
  logic [DW-1:0] cmd_arg;
`ifdef OBJ_SEQ_STATS_EN
  logic [15:0]   stat_entries, stat_skipped, stat_objects;
`endif

  obj_cmd_sequencer #(.DATA_W(DW), .KEY_W(KW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .in_kind(in_kind), .in_key(in_key), .in_data(in_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
    .cmd_arg(cmd_arg), .obj_done(obj_done), .err_orphan(err_orphan)
`ifdef OBJ_SEQ_STATS_EN
    , .stat_entries(stat_entries), .stat_skipped(stat_skipped), .stat_objects(stat_objects)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Entry-level model: each accepted entry expands into its expected command records
  typedef struct {
    logic [2:0]  op;
    logic [7:0]  idx;
    logic [31:0] arg;
    logic        done;
  } rec_t;
  rec_t expq[$];
  bit   m_open = 0;
  int   exp_done = 0, exp_orphan = 0, exp_entries = 0, exp_skipped = 0;

  function automatic void model_accept(bit first, bit last, logic [2:0] kind, logic [15:0] key, logic [31:0] data);
    bit pushable = (kind == 3'd1) || (kind == 3'd2) || (kind == 3'd3) || (kind == 3'd4);
    rec_t r;
    exp_entries++;
    if (!first && !m_open) begin
      exp_orphan++;
      return;
    end
    if (first) begin
      if (m_open) exp_done++;
      m_open = 1;
      r = '{op: 3'd0, idx: 8'h00, arg: 32'd0, done: last && !pushable};
      expq.push_back(r);
    end
    if (pushable) begin
      case (kind)
        3'd1:    r = '{op: 3'd1, idx: 8'h00, arg: data, done: 1'b0};
        3'd2:    r = '{op: 3'd2, idx: 8'h00, arg: data, done: 1'b0};
        3'd3:    r = '{op: 3'd3, idx: 8'h00, arg: {31'd0, data[0]}, done: 1'b0};
        default: r = '{op: 3'd4, idx: 8'h00, arg: 32'd0, done: 1'b0};
      endcase
      expq.push_back(r);
      r = '{op: 3'd5, idx: 8'hFE, arg: {16'd0, key}, done: last};
      expq.push_back(r);
    end else begin
      exp_skipped++;
    end
    if (last) begin
      m_open = 0;
      exp_done++;
    end
  endfunction

  // Compare process: every handshake is matched against the model, stalls must hold fields
  logic [2:0]  log_op[$];
  logic [7:0]  log_idx[$];
  logic [31:0] log_arg[$];
  logic        log_done[$];
  int          log_cyc[$];
  int          got_done = 0, got_orphan = 0;
  bit          prev_stall = 0;
  logic [2:0]  p_op;
  logic [7:0]  p_idx;
  logic [31:0] p_arg;

  always @(negedge clk) begin
    rec_t r;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", cmd_valid, 1'b1);
        chk("stall_op", cmd_op, p_op);
        chk("stall_idx", cmd_idx, p_idx);
        chk("stall_arg", cmd_arg, p_arg);
      end
      if (cmd_valid && cmd_ready) begin
        chk("cmd_expected", expq.size() != 0, 1'b1);
        if (expq.size() != 0) begin
          r = expq.pop_front();
          chk("cmd_op", cmd_op, r.op);
          chk("cmd_idx", cmd_idx, r.idx);
          chk("cmd_arg", cmd_arg, r.arg);
          if (r.done) chk("obj_done_at_final", obj_done, 1'b1);
        end
        log_op.push_back(cmd_op);
        log_idx.push_back(cmd_idx);
        log_arg.push_back(cmd_arg);
        log_done.push_back(obj_done);
        log_cyc.push_back(cyc);
      end
      if (obj_done) got_done++;
      if (err_orphan) got_orphan++;
      prev_stall = cmd_valid && !cmd_ready;
      p_op = cmd_op; p_idx = cmd_idx; p_arg = cmd_arg;
    end
  end

  bit rand_ready = 0;
  always @(posedge clk) begin
    #1;
    if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
  end

  int last_acc_cyc = 0;

  task automatic send(input bit first, input bit last, input logic [2:0] kind, input logic [15:0] key, input logic [31:0] data);
    bit acc = 0;
    in_valid = 1; in_first = first; in_last = last; in_kind = kind; in_key = key; in_data = data;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        last_acc_cyc = cyc;
        model_accept(first, last, kind, key, data);
      end
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
    in_valid = 0; in_first = 0; in_last = 0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(posedge clk); #1;
      if (expq.size() == 0 && !cmd_valid) ok = 1;
    end
    if (!ok) chk("drain_timeout", 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    expq.delete();
    m_open = 0; exp_entries = 0; exp_skipped = 0;
    #1;
    chk("rst_cmd_valid_async", cmd_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_cmd_op", cmd_op, 3'd0);
    chk("rst_cmd_idx", cmd_idx, 8'h00);
    chk("rst_cmd_arg", cmd_arg, 32'd0);
    chk("rst_obj_done", obj_done, 1'b0);
    chk("rst_err_orphan", err_orphan, 1'b0);
    rst_n = 1;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  int t1_op [9] = '{0, 1, 5, 2, 5, 3, 5, 4, 5};
  int t1_arg[9] = '{0, 'h10, 1, 7, 2, 1, 3, 0, 4};
  int t1_acc;

  initial begin
    do_reset();

    // Orphan entry right after reset: pulse only, no commands
    send(0, 0, 3'd1, 16'd9, 32'h99);
    repeat (3) @(posedge clk);
    #1;
    chk("orphan_pulses", got_orphan, 1);
    chk("orphan_no_cmd", log_op.size(), 0);
    chk("orphan_cmd_valid", cmd_valid, 1'b0);

    // Four-entry object with cmd_ready held high
    log_op.delete(); log_idx.delete(); log_arg.delete(); log_done.delete(); log_cyc.delete();
    send(1, 0, 3'd1, 16'd1, 32'h10);
    t1_acc = last_acc_cyc;
    send(0, 0, 3'd2, 16'd2, 32'd7);
    send(0, 0, 3'd3, 16'd3, 32'h5);
    send(0, 1, 3'd4, 16'd4, 32'hDEAD);
    drain();
    chk("t1_count", log_op.size(), 9);
    if (log_op.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        chk("t1_op", log_op[i], 64'(t1_op[i]));
        chk("t1_arg", log_arg[i], 64'(t1_arg[i]));
        chk("t1_idx", log_idx[i], (t1_op[i] == 5) ? 64'hFE : 64'h0);
        chk("t1_done", log_done[i], (i == 8) ? 64'd1 : 64'd0);
      end
      chk("t1_first_latency", log_cyc[0] - t1_acc, 1);
      chk("t1_span", log_cyc[8] - log_cyc[0], 8);
    end

    // Same object under random backpressure
    log_op.delete(); log_idx.delete(); log_arg.delete(); log_done.delete(); log_cyc.delete();
    rand_ready = 1;
    send(1, 0, 3'd1, 16'd1, 32'h10);
    send(0, 0, 3'd2, 16'd2, 32'd7);
    send(0, 0, 3'd3, 16'd3, 32'h5);
    send(0, 1, 3'd4, 16'd4, 32'hDEAD);
    drain();
    rand_ready = 0;
    cmd_ready = 1;
    chk("t2_count", log_op.size(), 9);
    if (log_op.size() == 9)
      for (int i = 0; i < 9; i++) chk("t2_op", log_op[i], 64'(t1_op[i]));

    // Empty object: NEW_OBJ alone carries obj_done
    log_op.delete(); log_idx.delete(); log_arg.delete(); log_done.delete(); log_cyc.delete();
    send(1, 1, 3'd0, 16'd0, 32'd0);
    drain();
    chk("empty_count", log_op.size(), 1);
    if (log_op.size() == 1) begin
      chk("empty_op", log_op[0], 3'd0);
      chk("empty_done", log_done[0], 1'b1);
    end

    // Reserved kind mid-object is skipped; implicit close by a new first entry
    send(1, 0, 3'd1, 16'd11, 32'hAB);
    send(0, 0, 3'd6, 16'd12, 32'hCD);
    send(0, 0, 3'd2, 16'd13, 32'h123);
    send(1, 1, 3'd3, 16'd14, 32'h3);
    send(1, 0, 3'd4, 16'd15, 32'h0);
    send(0, 1, 3'd7, 16'd16, 32'h1);
    drain();

    // Reset between PUSH_INT and its SET_PROP
    log_op.delete(); log_idx.delete(); log_arg.delete(); log_done.delete(); log_cyc.delete();
    send(1, 0, 3'd2, 16'd5, 32'd7);
    for (int t = 0; t < 100 && log_op.size() < 2; t++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_set_valid", cmd_valid, 1'b1);
    chk("pre_rst_set_op", cmd_op, 3'd5);
    do_reset();
    log_op.delete(); log_idx.delete(); log_arg.delete(); log_done.delete(); log_cyc.delete();
    send(1, 1, 3'd1, 16'd9, 32'h55);
    drain();
    chk("post_rst_count", log_op.size(), 3);
    if (log_op.size() == 3) begin
      chk("post_rst_op0", log_op[0], 3'd0);
      chk("post_rst_arg1", log_arg[1], 32'h55);
      chk("post_rst_done2", log_done[2], 1'b1);
    end

    chk("total_obj_done", got_done, exp_done);
    chk("total_orphan", got_orphan, exp_orphan);
    chk("model_drained", expq.size(), 0);
`ifdef OBJ_SEQ_STATS_EN
    chk("stat_entries", stat_entries, exp_entries);
    chk("stat_skipped", stat_skipped, exp_skipped);
    chk("stat_objects_post_rst", stat_objects, 1);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
